// File: rtl/trace_pkt_serializer_pkg.sv
// Core trace packet type plus serializer record/state types and slot-search helper.
// RV_TRACE_TIMESTAMP_EN adds a 32-bit tstamp field to trace_rec_t.
package veer_types;
    typedef struct packed {
        logic [2:0]  trace_rv_i_valid_ip;
        logic [95:0] trace_rv_i_insn_ip;
        logic [95:0] trace_rv_i_address_ip;
        logic [2:0]  trace_rv_i_exception_ip;
        logic [4:0]  trace_rv_i_ecause_ip;
        logic [2:0]  trace_rv_i_interrupt_ip;
        logic [31:0] trace_rv_i_tval_ip;
    } trace_pkt_t;
endpackage

package trace_types;
    import veer_types::*;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] addr;
        logic        exc;
        logic        intr;
        logic [4:0]  ecause;
        logic [31:0] tval;
        logic [1:0]  slot;
        logic        last;
        logic        ovf;
`ifdef RV_TRACE_TIMESTAMP_EN
        logic [31:0] tstamp;
`endif
    } trace_rec_t;

    typedef enum logic {IDLE, EMIT} state_t;

    // Lowest valid slot at or above 'from'; 3 means no such slot.
    function automatic logic [1:0] first_valid_slot(input logic [2:0] valid, input logic [1:0] from);
        first_valid_slot = 2'd3;
        for (int i = 2; i >= 0; i--) begin
            if (valid[i] && (i >= int'(from)))
                first_valid_slot = 2'(i);
        end
    endfunction
endpackage

// File: rtl/trace_pkt_serializer_fifo.sv
// Single-push/single-pop packet FIFO with wrap-bit pointers and async active-low reset.
module trace_pkt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     i_push,
    input  logic [W-1:0]             i_wdata,
    input  logic                     i_pop,
    output logic [W-1:0]             o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty   = (r_wptr == r_rptr);
    assign o_count   = r_wptr - r_rptr;
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_rdata   = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push)
                r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)
                r_rptr <= r_rptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/trace_pkt_serializer.sv
// Buffers core trace packets and emits one record per valid slot on a valid/ready stream.
// RV_TRACE_TIMESTAMP_EN stamps each packet with a free-running cycle count at push.
module trace_pkt_serializer
    import veer_types::*;
    import trace_types::*;
#(
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst_l,
    input  trace_pkt_t      trace_pkt,
    output logic            rec_valid,
    input  logic            rec_ready,
    output trace_rec_t      rec,
    output logic            ovf_sticky,
    output logic [CNTW-1:0] drop_cnt,
    input  logic            ovf_clr
);
    localparam int AW   = $clog2(DEPTH);
    localparam int PKTW = $bits(trace_pkt_t);
`ifdef RV_TRACE_TIMESTAMP_EN
    localparam int FW   = PKTW + 32;
`else
    localparam int FW   = PKTW;
`endif

    state_t          r_state, w_state_next;
    logic [1:0]      r_slot_ptr, w_slot_next;
    logic            r_pend_ovf;
    logic            r_ovf_sticky;
    logic [CNTW-1:0] r_drop_cnt;

    logic [FW-1:0]   w_wdata, w_rdata;
    logic [AW:0]     w_count, w_count_next;
    logic            w_full, w_empty;
    logic            w_any_valid, w_push, w_drop, w_xfer, w_pop, w_last;
    trace_pkt_t      w_head;
    logic [1:0]      w_cur_slot, w_nxt_slot;
    logic [31:0]     w_insn [4];
    logic [31:0]     w_addr [4];
    logic [3:0]      w_exc4, w_intr4;

`ifdef RV_TRACE_TIMESTAMP_EN
    logic [31:0]     r_cycle;
    logic [31:0]     w_head_ts;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)
            r_cycle <= '0;
        else
            r_cycle <= r_cycle + 32'd1;
    end

    assign w_wdata   = {r_cycle, trace_pkt};
    assign w_head_ts = w_rdata[FW-1 -: 32];
`else
    assign w_wdata   = trace_pkt;
`endif

    assign w_any_valid = |trace_pkt.trace_rv_i_valid_ip;
    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
    assign w_push = w_any_valid & ~w_full;
    assign w_drop = w_any_valid & w_full;

    trace_pkt_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
        .clk     (clk),
        .rst_l   (rst_l),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head = trace_pkt_t'(w_rdata[PKTW-1:0]);

    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
        assign w_insn[gi] = w_head.trace_rv_i_insn_ip[32*gi +: 32];
        assign w_addr[gi] = w_head.trace_rv_i_address_ip[32*gi +: 32];
    end
    assign w_insn[3] = '0;
    assign w_addr[3] = '0;
    assign w_exc4    = {1'b0, w_head.trace_rv_i_exception_ip};
    assign w_intr4   = {1'b0, w_head.trace_rv_i_interrupt_ip};

    assign w_cur_slot   = first_valid_slot(w_head.trace_rv_i_valid_ip, r_slot_ptr);
    assign w_nxt_slot   = first_valid_slot(w_head.trace_rv_i_valid_ip, w_cur_slot + 2'd1);
    assign w_last       = (w_nxt_slot == 2'd3);
    assign rec_valid    = (r_state == EMIT);
    assign w_xfer       = rec_valid & rec_ready;
    assign w_pop        = w_xfer & w_last & ~w_empty;
    assign w_count_next = w_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

    always_comb begin
        rec = '0;
        if (r_state == EMIT) begin
            rec.insn = w_insn[w_cur_slot];
            rec.addr = w_addr[w_cur_slot];
            rec.exc  = w_exc4[w_cur_slot];
            rec.intr = w_intr4[w_cur_slot];
            if (w_exc4[w_cur_slot] | w_intr4[w_cur_slot]) begin
                rec.ecause = w_head.trace_rv_i_ecause_ip;
                rec.tval   = w_head.trace_rv_i_tval_ip;
            end
            rec.slot = w_cur_slot;
            rec.last = w_last;
            rec.ovf  = r_pend_ovf;
`ifdef RV_TRACE_TIMESTAMP_EN
            rec.tstamp = w_head_ts;
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_slot_next  = r_slot_ptr;
        case (r_state)
            IDLE: if (w_count_next != '0) w_state_next = EMIT;
            EMIT: begin
                if (w_xfer) begin
                    if (w_last) begin
                        w_slot_next  = '0;
                        w_state_next = (w_count_next != '0) ? EMIT : IDLE;
                    end else begin
                        w_slot_next  = w_cur_slot + 2'd1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state    <= IDLE;
            r_slot_ptr <= '0;
        end else begin
            r_state    <= w_state_next;
            r_slot_ptr <= w_slot_next;
        end
    end

    // A drop outranks both a same-cycle clear and a same-cycle record transfer.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_pend_ovf   <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_drop_cnt   <= '0;
        end else if (w_drop) begin
            r_pend_ovf   <= 1'b1;
            r_ovf_sticky <= 1'b1;
            if (ovf_clr)
                r_drop_cnt <= CNTW'(1);
            else if (r_drop_cnt != '1)
                r_drop_cnt <= r_drop_cnt + CNTW'(1);
        end else begin
            if (ovf_clr) begin
                r_ovf_sticky <= 1'b0;
                r_drop_cnt   <= '0;
            end
            if (w_xfer)
                r_pend_ovf <= 1'b0;
        end
    end

    assign ovf_sticky = r_ovf_sticky;
    assign drop_cnt   = r_drop_cnt;
endmodule
